// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

   // Transmit sequencer states, in frame order.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Parity modes selected by the PARITY parameter.
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Accumulator width: holds acc + BAUD (< CLK_HZ + BAUD) with one spare bit.
   function automatic int acc_width(input int clk_hz, input int baud);
      return $clog2(clk_hz + baud) + 1;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Phase-accumulator bit-period generator. Emits a one-cycle tick at the end of
// each bit period; bit periods are floor or ceil of CLK_HZ/BAUD cycles with an
// exact long-run average. clear_i holds the accumulator at zero so the first
// period after clear lasts a full bit time.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115200
) (
   input  logic sys_clk_i,
   input  logic sys_rstn_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int AW = acc_width(CLK_HZ, BAUD);

   logic [AW-1:0] acc_q;
   logic [AW-1:0] acc_sum;

   assign acc_sum = acc_q + AW'(BAUD);
   assign tick_o  = !clear_i && (acc_sum >= AW'(CLK_HZ));

   // Accumulate BAUD per cycle, subtract CLK_HZ on each tick, hold at zero while cleared.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         acc_q <= '0;
      end else if (clear_i) begin
         acc_q <= '0;
      end else if (tick_o) begin
         acc_q <= acc_sum - AW'(CLK_HZ);
      end else begin
         acc_q <= acc_sum;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO. Words are queued through a valid/ready
// port and sent LSB first as start, data, optional parity and stop bits.
//
// Handshake: a word transfers on the rising clock edge where tx_valid_i and
// tx_ready_o are both high. tx_ready_o depends only on the FIFO level (low when
// full, even if the sequencer pops in the same cycle); tx_valid_i while not
// ready is ignored and the producer must hold the word until it is accepted.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          sys_clk_i,
   input  logic                          sys_rstn_i,
   input  logic                          tx_valid_i,
   input  logic [DATA_BITS-1:0]          tx_data_i,
   output logic                          tx_ready_o,
   output logic                          uart_tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

   localparam int   PW      = $clog2(FIFO_DEPTH);
   localparam int   LW      = PW + 1;
   localparam int   BW      = $clog2(DATA_BITS);
   localparam logic ODD_PAR = (PARITY == PAR_ODD);

   // Reject illegal parameter combinations at elaboration.
   if (CLK_HZ / BAUD < 4) begin : g_bad_ratio
      $error("uart_tx_fifo: CLK_HZ/BAUD must be at least 4");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be 5..8");
   end
   if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
   end

   // ---------------------------------------------------------------- FIFO
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q;
   logic [PW-1:0]        rd_ptr_q;
   logic [LW-1:0]        level_q;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 push;
   logic                 pop;
   logic [DATA_BITS-1:0] head;
   logic                 head_par;

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
   assign push       = tx_valid_i && !fifo_full;
   assign head       = mem[rd_ptr_q];
   assign head_par   = (^head) ^ ODD_PAR;

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge sys_clk_i) begin
      if (push) begin
         mem[wr_ptr_q] <= tx_data_i;
      end
   end

   // Pointers wrap naturally at FIFO_DEPTH; level is unchanged on push+pop.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // ------------------------------------------------------ bit-period tick
   tx_state_e state_q;
   tx_state_e state_d;
   logic      tick;

   uart_baud_gen #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_baud_gen (
      .sys_clk_i  (sys_clk_i),
      .sys_rstn_i (sys_rstn_i),
      .clear_i    (state_q == ST_IDLE),
      .tick_o     (tick)
   );

   // ----------------------------------------------------------- sequencer
   logic [BW-1:0]        bit_idx_q;
   logic [BW-1:0]        bit_idx_d;
   logic                 stop_idx_q;
   logic                 stop_idx_d;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic                 par_q;
   logic                 par_d;
   logic                 tx_q;
   logic                 tx_d;

   // Sequencer registers; the line level is registered alongside the state.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         state_q    <= ST_IDLE;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
      end
   end

   // Next state, next line level and frame loading; the frame word and its
   // parity are latched at pop so later FIFO traffic cannot disturb it.
   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tx_d       = tx_q;
      pop        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               state_d = ST_START;
               pop     = 1'b1;
               shift_d = head;
               par_d   = head_par;
               tx_d    = 1'b0;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d   = ST_DATA;
               bit_idx_d = '0;
               tx_d      = shift_q[0];
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_idx_q == BW'(DATA_BITS - 1)) begin
                  if (PARITY != PAR_NONE) begin
                     state_d = ST_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d    = ST_STOP;
                     stop_idx_d = 1'b0;
                     tx_d       = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d    = ST_STOP;
               stop_idx_d = 1'b0;
               tx_d       = 1'b1;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                  if (!fifo_empty) begin
                     // Back-to-back: next start bit follows with no idle gap.
                     state_d = ST_START;
                     pop     = 1'b1;
                     shift_d = head;
                     par_d   = head_par;
                     tx_d    = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign uart_tx_o    = tx_q;
   assign tx_ready_o   = !fifo_full;
   assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;
   assign fifo_level_o = level_q;

endmodule
